pipe_ctl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core; owns the PC's advance/redirect decision.
- Arbitrates between three events: branch resolution in stage 3, load-use hazards from stage 2, and instruction-memory fetch completion.
- Drives the PC enable/select and the per-stage squash and bubble controls.
- Sits beside the PC and pipeline registers; contains no datapath, control only.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_ctl.sv | 87 ++++++++
 tb/tb_pipe_ctl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encodings and the NOP word the stage squash logic writes into squashed stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2,
    STALL    = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and async active-high reset; sticks at
// all-ones so a long-running performance count never wraps back to a small value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctl.sv
// Pipeline sequencing controller: arbitrates taken branches, load-use hazards
// and fetch completion into PC enable/redirect and per-stage squash/bubble controls.
module pipe_ctl
  import pipe_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   branch,
  input  logic                   hazard,
  input  logic                   imem_valid,
  output logic                   pc_en,
  output logic                   pc_redirect,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic                   bubble_s2,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       stall_cycles
);

  state_t cur;

  // Branch and hazard are ignored in REDIRECT/DRAIN: they come from wrong-path
  // instructions that are being squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= RUN;
    end else begin
      case (cur)
        RUN: begin
          if (branch)      cur <= REDIRECT;
          else if (hazard) cur <= STALL;
        end
        REDIRECT: cur <= DRAIN;
        DRAIN: begin
          if (imem_valid) cur <= RUN;
        end
        STALL: begin
          if (branch)       cur <= REDIRECT;
          else if (!hazard) cur <= RUN;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    flush       = '0;
    bubble_s2   = 1'b0;
    if (reset) begin
      flush = '1;
    end else begin
      case (cur)
        RUN: begin
          pc_en     = imem_valid & ~hazard & ~branch;
          bubble_s2 = hazard & ~branch;
        end
        REDIRECT: begin
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
          flush       = '1;
        end
        DRAIN: begin
          pc_en = imem_valid;
          flush = FLUSH_DEPTH'(1);
        end
        STALL: begin
          bubble_s2 = ~branch;
        end
      endcase
    end
  end

  assign state = cur;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (~pc_en),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctl.sv
// Scoreboard bench for pipe_ctl: stimulus pushes expected responses from an
// event-level reference model; a monitor pops and compares on each falling edge.
module tb_pipe_ctl;

  localparam int FD = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          branch = 1'b0;
  logic          hazard = 1'b0;
  logic          imem_valid = 1'b0;
  logic          pc_en;
  logic          pc_redirect;
  logic [FD-1:0] flush;
  logic          bubble_s2;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles;

  pipe_ctl #(.FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .branch       (branch),
    .hazard       (hazard),
    .imem_valid   (imem_valid),
    .pc_en        (pc_en),
    .pc_redirect  (pc_redirect),
    .flush        (flush),
    .bubble_s2    (bubble_s2),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       pc_en;
    logic       pc_redirect;
    logic [2:0] flush;
    logic       bubble_s2;
    logic [1:0] state;
    int         stall_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Reference model kept as pending events rather than an encoded state.
  bit redirect_due = 0;  // a taken branch was accepted last cycle
  bit target_wait  = 0;  // redirect issued, target fetch not yet returned
  bit held         = 0;  // a load-use hazard was accepted and not yet cleared
  int stall_count  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, predict the response.
  task automatic cycle(input string tag, input bit r, input bit b, input bit h, input bit v);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; branch = b; hazard = h; imem_valid = v;
    e.tag = tag; e.pc_redirect = 0; e.bubble_s2 = 0; e.flush = 3'b000;
    if (r) begin
      e.pc_en = 0; e.flush = 3'b111; e.state = 2'd0;
      redirect_due = 0; target_wait = 0; held = 0; stall_count = 0;
    end else if (redirect_due) begin
      e.pc_en = 1; e.pc_redirect = 1; e.flush = 3'b111; e.state = 2'd1;
      redirect_due = 0; target_wait = 1;
    end else if (target_wait) begin
      e.pc_en = v; e.flush = 3'b001; e.state = 2'd2;
      target_wait = !v;
    end else if (held) begin
      e.pc_en = 0; e.state = 2'd3;
      if (b) begin
        held = 0; redirect_due = 1;
      end else begin
        e.bubble_s2 = 1; held = h;
      end
    end else begin
      e.state = 2'd0;
      e.pc_en = v && !h && !b;
      e.bubble_s2 = h && !b;
      if (b) redirect_due = 1;
      else if (h) held = 1;
    end
    e.stall_cycles = stall_count;
    exp_q.push_back(e);
    if (!r && !e.pc_en && stall_count < (1 << CW) - 1) stall_count++;
  endtask

  // Monitor: outputs are present every cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".pc_en"},        16'(pc_en),        16'(e.pc_en));
        check({e.tag, ".pc_redirect"},  16'(pc_redirect),  16'(e.pc_redirect));
        check({e.tag, ".flush"},        16'(flush),        16'(e.flush));
        check({e.tag, ".bubble_s2"},    16'(bubble_s2),    16'(e.bubble_s2));
        check({e.tag, ".state"},        16'(state),        16'(e.state));
        check({e.tag, ".stall_cycles"}, 16'(stall_cycles), 16'(e.stall_cycles));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h_lvl;
    int wait_cnt;
    cycle("rst", 1, 0, 0, 1);
    cycle("rst", 1, 0, 0, 1);
    repeat (2) cycle("run", 0, 0, 0, 1);
    // Taken branch, then drain waits for the target fetch.
    cycle("br", 0, 1, 0, 1);
    cycle("redir", 0, 1, 1, 0);
    repeat (2) cycle("drain_wait", 0, 1, 1, 0);
    cycle("drain_done", 0, 0, 0, 1);
    cycle("run", 0, 0, 0, 1);
    // Load-use hazard held for three cycles.
    repeat (3) cycle("hazard", 0, 0, 1, 1);
    repeat (2) cycle("hazard_clr", 0, 0, 0, 1);
    // Branch arriving during a stall.
    repeat (2) cycle("stall", 0, 0, 1, 1);
    cycle("stall_br", 0, 1, 1, 1);
    cycle("redir_ign", 0, 1, 1, 1);
    cycle("drain_ign", 0, 0, 1, 1);
    cycle("run", 0, 0, 0, 1);
    // Fetch wait in RUN after a fresh reset.
    cycle("rst2", 1, 0, 0, 1);
    repeat (5) cycle("fetch_wait", 0, 0, 0, 0);
    cycle("fetch_ok", 0, 0, 0, 1);
    // Drain held for four cycles.
    cycle("br2", 0, 1, 0, 1);
    cycle("redir2", 0, 0, 0, 0);
    repeat (4) cycle("drain_hold", 0, 0, 0, 0);
    cycle("drain_end", 0, 0, 0, 1);
    // Branch, hazard and fetch all at once: branch wins.
    cycle("all3", 0, 1, 1, 1);
    cycle("all3_redir", 0, 0, 0, 1);
    cycle("all3_drain", 0, 0, 0, 1);
    // Saturation of the 4-bit stall counter.
    cycle("rst3", 1, 0, 0, 1);
    repeat (20) cycle("sat", 0, 0, 1, 1);
    repeat (3) cycle("sat_clr", 0, 0, 0, 1);
    // Reset asserted mid-redirect and mid-stall.
    cycle("br3", 0, 1, 0, 1);
    cycle("rst_mid_redir", 1, 0, 0, 1);
    cycle("after_rst", 0, 0, 0, 1);
    cycle("hz", 0, 0, 1, 1);
    cycle("rst_mid_stall", 1, 0, 1, 1);
    cycle("after_rst2", 0, 0, 0, 1);
    // Randomised traffic with sticky hazards and occasional resets.
    h_lvl = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) h_lvl = !h_lvl;
      cycle("rand",
            $urandom_range(0, 79) == 0,
            $urandom_range(0, 7) == 0,
            h_lvl,
            $urandom_range(0, 3) != 0);
    end
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
